laser_datapath: RTL and testbench

Datapath that serves the per-tower laser control FSM. It registers the car-in-range status and rasterises the laser beam from the tower to the target car as a Bresenham line, one VGA pixel per clock. It also replays the same line in black to erase it and runs the post-erase cool-down counter. Its `x`/`y`/`colour`/`plot` outputs feed the shared VGA arbiter; its `*_done` and `drawn` feedback returns to the control FSM.

---
 rtl/laser_datapath.sv | 180 ++++++++++++++++++
 tb/tb_laser_datapath.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_datapath.sv
// laser_datapath: range check, Bresenham beam draw/erase and cool-down timer.
// Define LASER_CIRCLE_RANGE_EN for a circular engagement region.
module laser_datapath #(
  parameter logic [7:0]  TOWER_X      = 8'd40,
  parameter logic [6:0]  TOWER_Y      = 7'd60,
  parameter logic [7:0]  RANGE        = 8'd30,
  parameter logic [23:0] DELAY_CYCLES = 24'd5_000_000,
  parameter logic [2:0]  LASER_COLOUR = 3'b100
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] car_x,
  input  logic [6:0] car_y,
  input  logic       car_valid,
  input  logic       draw_laser,
  input  logic       erase,
  input  logic       delay,
  output logic       car_in_range,
  output logic       draw_done,
  output logic       erase_done,
  output logic       delay_done,
  output logic       drawn,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot
);
  typedef enum logic [1:0] {IDLE, LINE, DONE} state_t;
  state_t state, state_nx;

  logic signed [8:0] rdx;
  logic signed [7:0] rdy;
  logic [8:0] rax;
  logic [7:0] ray;
  logic in_rng;

  assign rdx = $signed({1'b0, car_x}) - $signed({1'b0, TOWER_X});
  assign rdy = $signed({1'b0, car_y}) - $signed({1'b0, TOWER_Y});
  assign rax = rdx[8] ? $unsigned(-rdx) : $unsigned(rdx);
  assign ray = rdy[7] ? $unsigned(-rdy) : $unsigned(rdy);

`ifdef LASER_CIRCLE_RANGE_EN
  logic [16:0] ax2, ay2, r2;
  assign ax2 = {8'd0, rax};
  assign ay2 = {9'd0, ray};
  assign r2 = {9'd0, RANGE};
  assign in_rng = (ax2 * ax2 + ay2 * ay2) <= (r2 * r2);
`else
  assign in_rng = (rax <= {1'b0, RANGE}) && (ray <= RANGE);
`endif

  logic [7:0] cx, ex;
  logic [6:0] cy, ey;
  logic [8:0] adx;
  logic [7:0] ady;
  logic neg_x, neg_y;
  logic signed [10:0] err, err_nx;
  logic [2:0] col;
  logic is_erase, prev_draw, prev_erase, drawn_q;
  logic [23:0] cnt;
  logic in_rng_q;

  logic draw_edge, erase_edge;
  logic go_draw, go_erase, go_line;
  logic at_end, step_x, step_y;

  assign draw_edge = draw_laser & ~prev_draw;
  assign erase_edge = erase & ~prev_erase;
  assign go_erase = (state == IDLE) & erase_edge;
  assign go_draw = (state == IDLE) & draw_edge & ~erase_edge;
  assign go_line = go_draw | (go_erase & drawn_q);

  // draw starts from the live car; erase replays the latched endpoint
  logic [7:0] sel_x;
  logic [6:0] sel_y;
  logic signed [8:0] ldx;
  logic signed [7:0] ldy;
  logic [8:0] lax;
  logic [7:0] lay;
  logic signed [10:0] lax_s, lay_s;

  assign sel_x = go_draw ? car_x : ex;
  assign sel_y = go_draw ? car_y : ey;
  assign ldx = $signed({1'b0, sel_x}) - $signed({1'b0, TOWER_X});
  assign ldy = $signed({1'b0, sel_y}) - $signed({1'b0, TOWER_Y});
  assign lax = ldx[8] ? $unsigned(-ldx) : $unsigned(ldx);
  assign lay = ldy[7] ? $unsigned(-ldy) : $unsigned(ldy);
  assign lax_s = {2'b0, lax};
  assign lay_s = {3'b0, lay};

  logic signed [11:0] e2, lim_x, lim_y;
  logic signed [10:0] adx_s, ady_s;

  assign adx_s = {2'b0, adx};
  assign ady_s = {3'b0, ady};
  assign e2 = {err, 1'b0};
  assign lim_x = -{4'b0, ady};
  assign lim_y = {3'b0, adx};
  assign step_x = e2 > lim_x;
  assign step_y = e2 < lim_y;
  assign err_nx = err - (step_x ? ady_s : 11'sd0)
                      + (step_y ? adx_s : 11'sd0);
  assign at_end = (cx == ex) && (cy == ey);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (go_erase) state_nx = drawn_q ? LINE : DONE;
        else if (go_draw) state_nx = LINE;
      end
      LINE: if (at_end) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cx <= '0;
      cy <= '0;
      ex <= '0;
      ey <= '0;
      adx <= '0;
      ady <= '0;
      neg_x <= 1'b0;
      neg_y <= 1'b0;
      err <= '0;
      col <= '0;
      is_erase <= 1'b0;
      prev_draw <= 1'b0;
      prev_erase <= 1'b0;
      drawn_q <= 1'b0;
      cnt <= '0;
      in_rng_q <= 1'b0;
    end else begin
      prev_draw <= draw_laser;
      prev_erase <= erase;
      in_rng_q <= car_valid & in_rng;
      if (go_draw) begin
        ex <= car_x;
        ey <= car_y;
      end
      if (go_erase) is_erase <= 1'b1;
      else if (go_draw) is_erase <= 1'b0;
      if (go_line) begin
        cx <= TOWER_X;
        cy <= TOWER_Y;
        adx <= lax;
        ady <= lay;
        neg_x <= ldx[8];
        neg_y <= ldy[7];
        err <= lax_s - lay_s;
        col <= go_erase ? 3'b000 : LASER_COLOUR;
      end else if (state == LINE && !at_end) begin
        if (step_x) cx <= neg_x ? cx - 8'd1 : cx + 8'd1;
        if (step_y) cy <= neg_y ? cy - 7'd1 : cy + 7'd1;
        err <= err_nx;
      end
      if (state == DONE) drawn_q <= ~is_erase;
      if (!delay) cnt <= '0;
      else if (cnt != DELAY_CYCLES) cnt <= cnt + 24'd1;
    end
  end

  assign car_in_range = in_rng_q;
  assign plot = (state == LINE);
  assign draw_done = (state == DONE) & ~is_erase;
  assign erase_done = (state == DONE) & is_erase;
  assign drawn = drawn_q;
  assign delay_done = (cnt == DELAY_CYCLES);
  assign x = cx;
  assign y = cy;
  assign colour = col;
endmodule

// File: tb/tb_laser_datapath.sv
// tb_laser_datapath: directed and random checks of laser_datapath
// against a queue-based pixel model.
module tb_laser_datapath;
  localparam int TX = 40, TY = 60, RG = 30, DLY = 4;

  logic clk, resetn;
  logic [7:0] car_x;
  logic [6:0] car_y;
  logic car_valid, draw_laser, erase, delay;
  logic car_in_range, draw_done, erase_done, delay_done, drawn, plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  laser_datapath #(.DELAY_CYCLES(24'd4)) dut (
    .clk(clk), .resetn(resetn),
    .car_x(car_x), .car_y(car_y), .car_valid(car_valid),
    .draw_laser(draw_laser), .erase(erase), .delay(delay),
    .car_in_range(car_in_range), .draw_done(draw_done),
    .erase_done(erase_done), .delay_done(delay_done),
    .drawn(drawn), .x(x), .y(y), .colour(colour), .plot(plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // model: expected pixel stream kept as a queue
  int qx[$], qy[$];
  logic m_plot = 0, m_dd = 0, m_ed = 0, m_drawn = 0, m_cir = 0;
  logic m_pd = 0, m_pe = 0, m_ers = 0;
  int m_x = 0, m_y = 0, m_col = 0, m_cnt = 0, m_ex = 0, m_ey = 0;

  function automatic void build(input int x1, input int y1);
    int px, py, ax, ay, sx, sy, e, e2;
    px = TX;
    py = TY;
    ax = (x1 > TX) ? x1 - TX : TX - x1;
    ay = (y1 > TY) ? y1 - TY : TY - y1;
    sx = (x1 >= TX) ? 1 : -1;
    sy = (y1 >= TY) ? 1 : -1;
    e = ax - ay;
    qx.delete();
    qy.delete();
    for (int n = 0; n < 400; n++) begin
      qx.push_back(px);
      qy.push_back(py);
      if (px == x1 && py == y1) break;
      e2 = 2 * e;
      if (e2 > -ay) begin e -= ay; px += sx; end
      if (e2 < ax) begin e += ax; py += sy; end
    end
  endfunction

  initial forever begin
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      qx.delete();
      qy.delete();
      m_plot = 0; m_dd = 0; m_ed = 0; m_drawn = 0; m_cir = 0;
      m_pd = 0; m_pe = 0; m_ers = 0;
      m_x = 0; m_y = 0; m_col = 0; m_cnt = 0; m_ex = 0; m_ey = 0;
    end else begin : upd
      logic wp, wdd, wed, idle, de, ee;
      int ax, ay;
      wp = m_plot;
      wdd = m_dd;
      wed = m_ed;
      idle = !wp && !wdd && !wed;
      de = draw_laser && !m_pd;
      ee = erase && !m_pe;
      if (wdd) m_drawn = 1;
      if (wed) m_drawn = 0;
      m_dd = 0;
      m_ed = 0;
      if (idle && ee) begin
        m_ers = 1;
        if (m_drawn) begin
          build(m_ex, m_ey);
          m_col = 0;
        end else m_ed = 1;
      end else if (idle && de) begin
        m_ers = 0;
        m_ex = int'(car_x);
        m_ey = int'(car_y);
        build(m_ex, m_ey);
        m_col = 4;
      end
      if (wp && qx.size() == 0) begin
        if (m_ers) m_ed = 1;
        else m_dd = 1;
      end
      if (qx.size() > 0) begin
        m_plot = 1;
        m_x = qx.pop_front();
        m_y = qy.pop_front();
      end else m_plot = 0;
      ax = int'(car_x) - TX;
      ay = int'(car_y) - TY;
      if (ax < 0) ax = -ax;
      if (ay < 0) ay = -ay;
`ifdef LASER_CIRCLE_RANGE_EN
      m_cir = car_valid && (ax * ax + ay * ay <= RG * RG);
`else
      m_cir = car_valid && ax <= RG && ay <= RG;
`endif
      if (delay) begin
        if (m_cnt < DLY) m_cnt++;
      end else m_cnt = 0;
      m_pd = draw_laser;
      m_pe = erase;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("plot", plot, m_plot);
    chk("x", x, m_x);
    chk("y", y, m_y);
    if (m_plot) chk("colour", colour, m_col);
    chk("draw_done", draw_done, m_dd);
    chk("erase_done", erase_done, m_ed);
    if (!(m_dd || m_ed)) chk("drawn", drawn, m_drawn);
    chk("car_in_range", car_in_range, m_cir);
    chk("delay_done", delay_done, int'(m_cnt == DLY));
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic line_pass(input string tag, input int np_exp,
                           input int xl, input int yl, input int col,
                           input bit ers, input bit ychk);
    int np;
    np = 0;
    nxt();
    draw_laser = 0;
    erase = 0;
    chk({tag, "_x0"}, x, TX);
    chk({tag, "_y0"}, y, TY);
    chk({tag, "_col"}, colour, col);
    for (int i = 1; i <= np_exp; i++) begin
      np += int'(plot);
      if (ychk) chk({tag, "_ystep"}, y, TY + i - 1);
      if (i == np_exp) begin
        chk({tag, "_xlast"}, x, xl);
        chk({tag, "_ylast"}, y, yl);
      end
      nxt();
    end
    chk({tag, "_plots"}, np, np_exp);
    chk({tag, "_done"}, ers ? erase_done : draw_done, 1);
    chk({tag, "_noplot"}, plot, 0);
    nxt();
    nxt();
    chk({tag, "_drawn"}, drawn, int'(!ers));
  endtask

  initial begin
    int nd;
    resetn = 1; car_x = 0; car_y = 0; car_valid = 0;
    draw_laser = 0; erase = 0; delay = 0;
    #1 resetn = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_plot", plot, 0);
    chk("rst_x", x, 0);
    chk("rst_drawn", drawn, 0);
    chk("rst_cir", car_in_range, 0);
    chk("rst_delay_done", delay_done, 0);
    nxt();
    resetn = 1;

    car_valid = 1; car_x = 70; car_y = 60;
    nxt(); chk("range_in_x", car_in_range, 1);
    car_x = 71;
    nxt(); chk("range_out_x", car_in_range, 0);
    car_x = 70; car_valid = 0;
    nxt(); chk("range_invalid", car_in_range, 0);
    car_valid = 1; car_x = 40; car_y = 90;
    nxt(); chk("range_in_y", car_in_range, 1);
    car_y = 29;
    nxt(); chk("range_out_y", car_in_range, 0);

    car_x = 50; car_y = 60; draw_laser = 1;
    line_pass("horiz", 11, 50, 60, 4, 0, 0);

    car_x = 100; car_y = 100; erase = 1;
    line_pass("erase", 11, 50, 60, 0, 1, 0);

    erase = 1;
    nxt();
    erase = 0;
    chk("erase_empty_done", erase_done, 1);
    chk("erase_empty_plot", plot, 0);
    nxt();
    chk("erase_empty_once", erase_done, 0);
    nxt();

    car_x = 45; car_y = 70; draw_laser = 1;
    line_pass("steep", 11, 45, 70, 4, 0, 1);
    erase = 1;
    line_pass("erase_steep", 11, 45, 70, 0, 1, 0);

    car_x = 40; car_y = 60; draw_laser = 1;
    line_pass("zero", 1, 40, 60, 4, 0, 0);
    erase = 1;
    line_pass("erase_zero", 1, 40, 60, 0, 1, 0);

    delay = 1;
    for (int i = 1; i <= DLY; i++) begin
      nxt();
      chk("delay_rise", delay_done, int'(i == DLY));
    end
    nxt();
    nxt();
    chk("delay_hold", delay_done, 1);
    delay = 0;
    nxt();
    chk("delay_clear", delay_done, 0);

    car_x = 50; car_y = 60; draw_laser = 1;
    nxt();
    draw_laser = 0;
    repeat (4) nxt();
    chk("mid_x", x, 44);
    chk("mid_plot", plot, 1);
    #1 resetn = 0;
    #1;
    chk("async_plot", plot, 0);
    chk("async_x", x, 0);
    chk("async_y", y, 0);
    chk("async_colour", colour, 0);
    chk("async_done", draw_done, 0);
    nxt();
    resetn = 1;
    nd = 0;
    repeat (15) begin
      nxt();
      nd += int'(draw_done) + int'(plot);
    end
    chk("no_activity_after_rst", nd, 0);
    draw_laser = 1;
    line_pass("restart", 11, 50, 60, 4, 0, 0);

    draw_laser = 1; erase = 1;
    line_pass("both_erase_wins", 11, 50, 60, 0, 1, 0);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        car_x = 8'($urandom_range(0, 110));
        car_y = 7'($urandom_range(10, 110));
        car_valid = ($urandom_range(0, 7) != 0);
      end
      if ($urandom_range(0, 9) == 0) draw_laser = ~draw_laser;
      if ($urandom_range(0, 14) == 0) erase = ~erase;
      if ($urandom_range(0, 19) == 0) delay = ~delay;
      nxt();
    end
    draw_laser = 0; erase = 0; delay = 0;
    repeat (200) nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
